bus_ram_responder: RTL and testbench
====================================

// Module: bus_ram_responder
// PURPOSE
//  Bus-side slave terminating the single-master request/ack bus driven by the 2x1 arbiter.
//  Word-organised RAM with byte/half/word access, configurable wait states, sign/zero-extended reads, error ack.
//  Sits behind the arbiter output (o_bus_en/o_wr_rd/o_wr_data/o_addr/o_size in, i_ack/i_rd_data back).
// PARAMETERS
//  DEPTH_LOG2   10            log2 of RAM depth in 32-bit words (1024 words = 4 KiB)
//  BASE_ADDR    32'h0000_0000 byte base address; must be aligned to 4*2^DEPTH_LOG2
//  WAIT_STATES  1             extra cycles between request acceptance and ack (0..15)
// PORTS
//  i_clk        in   1   clock; all state updates on rising edge
//  i_rst        in   1   reset; synchronous, active-low
//  i_bus_en     in   1   request valid
//  i_wr_rd      in   1   1 = write, 0 = read
//  i_wr_data    in   32  write data, right-justified (byte in [7:0], half in [15:0])
//  i_addr       in   32  byte address
//  i_size       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (bit2 = unsigned, reads only)
//  o_ack        out  1   one-cycle completion pulse
//  o_err        out  1   valid only with o_ack; 1 = request rejected, no RAM effect
//  o_rd_data    out  32  read data, valid with o_ack on non-error read, held otherwise
// BEHAVIOUR
//  Reset (i_rst=0 at edge): state IDLE, wait counter 0, o_ack=0, o_err=0, o_rd_data=0. RAM contents not reset.
//  FSM: IDLE -> WAIT -> ACK -> RELEASE -> IDLE.
//   IDLE: i_bus_en=1 at edge -> latch wr_rd/wr_data/addr/size, load counter=WAIT_STATES; go WAIT (or ACK if 0).
//   WAIT: counter decrements each cycle; at counter==1 edge go ACK. Master input changes ignored (latched copy).
//   Entering ACK edge: perform write / capture read / compute error; o_ack=1 for exactly the ACK cycle.
//   ACK -> RELEASE unconditionally. RELEASE: stay while i_bus_en=1; i_bus_en=0 -> IDLE.
//  Latency: request sampled edge N -> o_ack high in cycle N+1+WAIT_STATES. No back-to-back: master must drop
//   i_bus_en for >=1 cycle after ack before the next request is accepted (arbiter re-grant naturally does this).
//  i_bus_en dropped during WAIT: transaction still completes and acks; RELEASE then exits next edge.
//  Error (o_err=1 with o_ack, RAM unchanged, o_rd_data unchanged) when any of:
//   addr outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2); size in {011,110,111}; write with size bit2=1;
//   half with addr[0]=1; word with addr[1:0]!=0.
//  Index = (addr-BASE_ADDR)[DEPTH_LOG2+1:2]; little-endian lanes by addr[1:0].
//  Writes: B updates lane addr[1:0] with wr_data[7:0]; H updates lanes {addr[1],0},{addr[1],1} with wr_data[15:0];
//   W updates all lanes. Unselected lanes preserved (read-modify-write or byte enables, implementer's choice).
//  Reads: B/H sign-extend from bit 7/15; BU/HU zero-extend; W unchanged. Writes leave o_rd_data unchanged.
//  Reset mid-transaction: in-flight request dropped; a write not yet at the ACK-entry edge is never committed.
//  o_err=0 whenever o_ack=0.
// TESTING
//  1. WAIT_STATES=1: write W 0xDEADBEEF @0x10, then read W @0x10 -> ack 2 cycles after each sample, rd=0xDEADBEEF, err=0.
//  2. Write B 0x80 @0x11 over 0xDEADBEEF; read B @0x11 -> 0xFFFFFF80; BU -> 0x00000080; W @0x10 -> 0xDEAD80EF.
//  3. Read H @0x13, W @0x12, size 011, write BU @0x10, addr 0x1000 -> each o_ack=1,o_err=1; RAM and o_rd_data unchanged.
//  4. Hold i_bus_en=1 after ack -> no second ack until i_bus_en low one cycle; drop bus_en in WAIT -> ack still issued.
//  5. Assert i_rst=0 during WAIT of a write 0x12345678 @0x20 -> no ack, outputs 0; later read @0x20 returns prior value.
//  6. WAIT_STATES=0 and 3 builds: ack at N+1 and N+4 respectively; random B/H/W traffic vs. reference memory model.

Source files
------------

// File: rtl/bus_ram_responder_if.sv
// Request/ack bus between the arbiter output (master) and the RAM responder (slave).
interface bus_ram_responder_if;
  logic        i_bus_en;
  logic        i_wr_rd;
  logic [31:0] i_wr_data;
  logic [31:0] i_addr;
  logic [2:0]  i_size;
  logic        o_ack;
  logic        o_err;
  logic [31:0] o_rd_data;

  modport master (
    output i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size,
    input  o_ack, o_err, o_rd_data
  );

  modport slave (
    input  i_bus_en, i_wr_rd, i_wr_data, i_addr, i_size,
    output o_ack, o_err, o_rd_data
  );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-organised RAM slave with byte/half/word access, programmable wait states,
// sign/zero-extended reads and an error ack for illegal or out-of-range requests.
module bus_ram_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  bus_ram_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t      r_state;
  logic [3:0]  r_waitCnt;
  logic        r_wrRd;
  logic [31:0] r_wrData;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdData;
  logic [31:0] r_mem [DEPTH];

  logic                  w_useIn;
  logic                  w_enterAck;
  logic                  w_wrRd;
  logic [31:0]           w_wrData;
  logic [31:0]           w_addr;
  logic [2:0]            w_size;
  logic [31:0]           w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;
  logic [31:0]           w_word;
  logic [7:0]            w_lane8;
  logic [15:0]           w_lane16;
  logic [3:0]            w_byteEn;
  logic [31:0]           w_wrWord;
  logic [31:0]           w_rdVal;

  // With zero wait states the request completes on the edge it is sampled,
  // so the live bus fields are used instead of the latched copy.
  assign w_useIn    = (r_state == S_IDLE);
  assign w_wrRd     = w_useIn ? bus.i_wr_rd   : r_wrRd;
  assign w_wrData   = w_useIn ? bus.i_wr_data : r_wrData;
  assign w_addr     = w_useIn ? bus.i_addr    : r_addr;
  assign w_size     = w_useIn ? bus.i_size    : r_size;
  assign w_enterAck = (w_useIn && bus.i_bus_en && (WAIT_STATES == 0)) ||
                      ((r_state == S_WAIT) && (r_waitCnt == 4'd1));

  assign w_offset = w_addr - BASE_ADDR;
  assign w_idx    = w_offset[DEPTH_LOG2+1:2];
  assign w_word   = r_mem[w_idx];

  always_comb begin
    w_err = (w_offset[31:DEPTH_LOG2+2] != '0);
    if ((w_size == 3'b011) || (w_size[2:1] == 2'b11)) w_err = 1'b1;
    if (w_wrRd && w_size[2]) w_err = 1'b1;
    if ((w_size[1:0] == 2'b01) && w_offset[0]) w_err = 1'b1;
    if ((w_size[1:0] == 2'b10) && (w_offset[1:0] != 2'b00)) w_err = 1'b1;
  end

  // Lane steering: replicated write data plus byte enables, and extended read data.
  always_comb begin
    w_lane8  = w_word[{w_offset[1:0], 3'b000} +: 8];
    w_lane16 = w_offset[1] ? w_word[31:16] : w_word[15:0];
    w_byteEn = 4'b1111;
    w_wrWord = w_wrData;
    w_rdVal  = w_word;
    case (w_size[1:0])
      2'b00: begin
        w_byteEn = 4'b0001 << w_offset[1:0];
        w_wrWord = {4{w_wrData[7:0]}};
        w_rdVal  = w_size[2] ? {24'd0, w_lane8} : {{24{w_lane8[7]}}, w_lane8};
      end
      2'b01: begin
        w_byteEn = w_offset[1] ? 4'b1100 : 4'b0011;
        w_wrWord = {2{w_wrData[15:0]}};
        w_rdVal  = w_size[2] ? {16'd0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && w_enterAck && !w_err && w_wrRd) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i]) r_mem[w_idx][8*i +: 8] <= w_wrWord[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 4'd0;
      r_wrRd    <= 1'b0;
      r_wrData  <= 32'd0;
      r_addr    <= 32'd0;
      r_size    <= 3'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdData  <= 32'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_enterAck) begin
        r_ack <= 1'b1;
        r_err <= w_err;
        if (!w_err && !w_wrRd) r_rdData <= w_rdVal;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.i_bus_en) begin
            r_wrRd    <= bus.i_wr_rd;
            r_wrData  <= bus.i_wr_data;
            r_addr    <= bus.i_addr;
            r_size    <= bus.i_size;
            r_waitCnt <= 4'(WAIT_STATES);
            r_state   <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_waitCnt <= r_waitCnt - 4'd1;
          if (r_waitCnt == 4'd1) r_state <= S_ACK;
        end
        S_ACK:     r_state <= S_RELEASE;
        S_RELEASE: if (!bus.i_bus_en) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ack     = r_ack;
  assign bus.o_err     = r_err;
  assign bus.o_rd_data = r_rdData;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Drives three responders (0, 1 and 3 wait states) with identical traffic and
// scores each against a byte-addressed reference memory.
module tb_bus_ram_responder;

  typedef struct {
    bit        err;
    bit [31:0] rd;
    int        ackCyc;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        busEn;
  logic        wrRd;
  logic [31:0] wrData;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [2:0]  ackV;
  logic [2:0]  errV;
  logic [31:0] rdV [3];

  int        checks = 0;
  int        errors = 0;
  int        cyc    = 0;
  exp_t      expQ [3][$];
  bit [7:0]  modelMem [3][4096];
  bit [31:0] lastRd [3];

  bus_ram_responder_if busIf [3] ();

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gDut
      assign busIf[g].i_bus_en  = busEn;
      assign busIf[g].i_wr_rd   = wrRd;
      assign busIf[g].i_wr_data = wrData;
      assign busIf[g].i_addr    = addr;
      assign busIf[g].i_size    = size;
      assign ackV[g]            = busIf[g].o_ack;
      assign errV[g]            = busIf[g].o_err;
      assign rdV[g]             = busIf[g].o_rd_data;

      bus_ram_responder #(
        .DEPTH_LOG2 (10),
        .BASE_ADDR  (32'h0000_0000),
        .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) dut (
        .i_clk(clk),
        .i_rst(rstN),
        .bus  (busIf[g].slave)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wsOf(int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic checkOutput(string name, int d, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, d, act, expv);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, rules applied directly.
  task automatic modelRequest(int d, bit wr, bit [31:0] data, bit [31:0] a, bit [2:0] sz,
                              int sample, output exp_t e);
    bit        err;
    int        n;
    bit [31:0] v;
    err = (a >= 32'h1000) || (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) ||
          (wr && sz[2]) || ((sz[1:0] == 2'b01) && a[0]) ||
          ((sz[1:0] == 2'b10) && (a[1:0] != 2'b00));
    n = (sz[1:0] == 2'b00) ? 1 : ((sz[1:0] == 2'b01) ? 2 : 4);
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) modelMem[d][int'(a) + i] = data[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(modelMem[d][int'(a) + i]) << (8 * i));
        if (!sz[2] && (n < 4) && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        lastRd[d] = v;
      end
    end
    e.err    = err;
    e.rd     = lastRd[d];
    e.ackCyc = sample + wsOf(d);
  endtask

  // mode 0: one-cycle request pulse; 1: hold bus_en long after ack; 2: reset after sampling.
  task automatic applyStimulus(bit wr, bit [31:0] data, bit [31:0] a, bit [2:0] sz, int mode);
    int   sample;
    exp_t e;
    @(negedge clk);
    busEn  = 1'b1;
    wrRd   = wr;
    wrData = data;
    addr   = a;
    size   = sz;
    sample = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if ((mode != 2) || (wsOf(d) == 0)) begin
        modelRequest(d, wr, data, a, sz, sample, e);
        expQ[d].push_back(e);
      end
    end
    if (mode == 1) begin
      repeat (7) @(negedge clk);
      busEn = 1'b0;
      repeat (3) @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      busEn = 1'b0;
      rstN  = 1'b0;
      for (int d = 0; d < 3; d++) lastRd[d] = 32'd0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checkOutput("rst_ack", d, {31'd0, ackV[d]}, 32'd0);
        checkOutput("rst_rd_data", d, rdV[d], 32'd0);
      end
      rstN = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      @(negedge clk);
      busEn = 1'b0;
      repeat (6) @(negedge clk);
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("acks_pending", d, expQ[d].size(), 32'd0);
      if (expQ[d].size() != 0) expQ[d].delete();
    end
  endtask

  // Monitor: every ack pops the oldest expectation for that responder.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ackV[d] === 1'b1) begin
        if (expQ[d].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack dut%0d: got ack, expected none", d);
        end else begin
          exp_t e;
          e = expQ[d].pop_front();
          checkOutput("err", d, {31'd0, errV[d]}, {31'd0, e.err});
          checkOutput("rd_data", d, rdV[d], e.rd);
          checkOutput("ack_cycle", d, cyc, e.ackCyc);
        end
      end else if (errV[d] !== 1'b0) begin
        checkOutput("err_without_ack", d, {31'd0, errV[d]}, 32'd0);
      end
    end
  end

  initial begin
    bit [2:0] sizeTbl [10];
    bit [31:0] a;
    sizeTbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    rstN   = 1'b0;
    busEn  = 1'b0;
    wrRd   = 1'b0;
    wrData = 32'd0;
    addr   = 32'd0;
    size   = 3'd0;
    for (int d = 0; d < 3; d++) lastRd[d] = 32'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_ack", d, {31'd0, ackV[d]}, 32'd0);
      checkOutput("reset_err", d, {31'd0, errV[d]}, 32'd0);
      checkOutput("reset_rd_data", d, rdV[d], 32'd0);
    end
    rstN = 1'b1;

    for (int w = 0; w < 64; w++) applyStimulus(1'b1, $urandom, 32'(w * 4), 3'b010, 0);

    $display("[TB] directed word/byte accesses");
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h10, 3'b010, 0);
    applyStimulus(1'b0, $urandom, 32'h10, 3'b010, 0);
    applyStimulus(1'b1, 32'h0000_0080, 32'h11, 3'b000, 0);
    applyStimulus(1'b0, $urandom, 32'h11, 3'b000, 0);
    applyStimulus(1'b0, $urandom, 32'h11, 3'b100, 0);
    applyStimulus(1'b0, $urandom, 32'h10, 3'b010, 0);

    $display("[TB] error requests");
    applyStimulus(1'b0, $urandom, 32'h13, 3'b001, 0);
    applyStimulus(1'b0, $urandom, 32'h12, 3'b010, 0);
    applyStimulus(1'b0, $urandom, 32'h10, 3'b011, 0);
    applyStimulus(1'b1, 32'h55, 32'h10, 3'b100, 0);
    applyStimulus(1'b0, $urandom, 32'h1000, 3'b010, 0);
    applyStimulus(1'b0, $urandom, 32'h10, 3'b010, 0);

    $display("[TB] held request and reset during wait");
    applyStimulus(1'b0, $urandom, 32'h12, 3'b101, 1);
    applyStimulus(1'b1, 32'hCAFEF00D, 32'h20, 3'b010, 0);
    applyStimulus(1'b1, 32'h12345678, 32'h20, 3'b010, 2);
    applyStimulus(1'b0, $urandom, 32'h20, 3'b010, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 250; n++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) a = 32'hFFFF_FFF0;
      applyStimulus(1'($urandom_range(0, 1)), $urandom, a, sizeTbl[$urandom_range(0, 9)],
                    ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
